systolic_input_feeder: RTL and testbench
========================================

// Module: systolic_input_feeder
// PURPOSE
// - Upstream stage of the systolic matmul array. Buffers one N x N activation matrix A, arriving one row per handshake.
// - On start, streams A into the array's left-edge inputs (a_in lanes) with diagonal skew plus a drain tail.
// - Replaces hand-sequenced a_in/valid stimulus with a self-timed feeder.
// PARAMETERS
// - DATA_W        16  width of one activation element (unsigned)
// - N             2   array dimension = lanes = rows buffered
// - DRAIN_CYCLES  3   zero-data cycles with a_valid=1 after skew; lets accumulators settle
// PORTS
// - clk        in   1         system clock, rising edge
// - reset      in   1         synchronous, active-high; clears all state
// - in_valid   in   1         in_row carries a valid row of A
// - in_ready   out  1         feeder can accept a row this cycle
// - in_row     in   N*DATA_W  row r of A; element c at [c*DATA_W +: DATA_W]
// - start      in   1         begin streaming (honoured only in READY)
// - busy       out  1         high in STREAM or DRAIN
// - done       out  1         one-cycle pulse after last drain cycle
// - a_out      out  N*DATA_W  lane i at [i*DATA_W +: DATA_W]; lane i drives array a_in(i+1)
// - a_valid    out  1         drives array valid
// BEHAVIOUR
// - One clock (clk). Reset is synchronous and active-high (reset). All outputs are registered.
// - Reset values: in_ready=0, busy=0, done=0, a_valid=0, a_out=0, state=IDLE, counters=0.
// - Reset mid-operation aborts immediately: no done pulse; buffer contents are discarded (row_cnt=0).
// - FSM: IDLE -> LOAD -> READY -> STREAM -> DRAIN -> IDLE.
//   - IDLE: in_ready=1 the cycle after reset deasserts; first accepted row -> LOAD.
//   - LOAD: in_ready=1 while row_cnt<N.
//   - Row transfer = in_valid & in_ready. It writes buf[row_cnt] and increments row_cnt.
//   - Transfer of row N-1 -> READY, and in_ready drops on the next cycle.
//   - READY: in_ready=0. start -> STREAM with t=0. start in IDLE/LOAD/STREAM/DRAIN is ignored (not queued).
//   - STREAM: t runs 0..2N-2. Registered output at each t:
//     - lane i = A[i][t-i] if 0 <= t-i < N, else 0.
//     - a_valid=1, busy=1.
//   - At t=2N-2 -> DRAIN.
//   - DRAIN: DRAIN_CYCLES cycles of a_out=0, a_valid=1, busy=1. After the last one -> IDLE.
//     - done=1 for exactly one cycle, in the same cycle a_valid returns to 0.
//     - row_cnt=0; in_ready=1 in that cycle.
//   - DRAIN_CYCLES=0: STREAM goes directly to the done cycle.
// - Latency: start sampled at edge k -> a_out/a_valid show t=0 data after edge k+1.
// - Total valid cycles = 2N-1+DRAIN_CYCLES.
// - No arithmetic on data; elements pass through bit-exact. Counter widths = $clog2 of max count + 1.
// - in_valid while in_ready=0 is ignored; in_row is not captured.
// CONFIGURATION
// - FEEDER_TRANSPOSE_EN defined: lane i streams column i of A, i.e. lane i = A[t-i][i] under the same skew window. Lets the array consume A^T without host reordering.
// - FEEDER_TRANSPOSE_EN undefined: row-wise streaming as above. Timing, handshake and FSM are identical in both builds.
// STRUCTURE
// - Package feeder_pkg:
//   - state typedef (IDLE, LOAD, READY, STREAM, DRAIN)
//   - default DATA_W constant
//   - lane-slice helper function
// - Sub-module feeder_row_buffer: N x N x DATA_W register file with one row write port and N element read ports, indexed by skew logic.
// - FSM, counters and skew mux stay in systolic_input_feeder.
// TESTING (N=2, DRAIN_CYCLES=3, A=[[11,12],[21,22]])
// - Reset: hold reset 2 cycles -> all outputs 0. Release -> next cycle in_ready=1, a_valid=0.
// - Load+stream: send rows {11,12}, {21,22}, then pulse start. Expected (lane0, lane1) sequence:
//   - (11,0), (12,21), (0,22), then (0,0) x3, all with a_valid=1
//   - then done=1 for one cycle
//   - expected array results: acc1=11*3+12*4=81, acc2=21*3+22*4... per array mapping
// - Handshake: in_valid held high for 3 rows -> only 2 accepted. in_ready=0 once READY. start before row 2 ignored.
// - Reset mid-STREAM at t=1: next cycle a_valid=0, busy=0, no done pulse. A reload and restream then matches the load+stream sequence.
// - Back-to-back: load the next A during the done cycle -> second stream is correct, with no stale data from the first.
// - FEEDER_TRANSPOSE_EN build: same stimulus -> (11,0), (21,12), (0,22), then (0,0) x3.

Source files
------------

// File: rtl/feeder_pkg.sv
// Shared types and helpers for the systolic input feeder.
package feeder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    READY,
    STREAM,
    DRAIN
  } state_e;

  localparam int FEEDER_DATA_W = 16;

  function automatic int laneLsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/feeder_row_buffer.sv
// N x N activation store: one full-row write port, N independent element read ports.
module feeder_row_buffer
  import feeder_pkg::*;
#(
  parameter int DATA_W = FEEDER_DATA_W,
  parameter int N      = 2,
  parameter int IW     = 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              wrEn_i,
  input  logic [IW-1:0]     wrRow_i,
  input  logic [N*DATA_W-1:0] wrData_i,
  input  logic [N*IW-1:0]   rdRow_i,
  input  logic [N*IW-1:0]   rdCol_i,
  output logic [N*DATA_W-1:0] rdData_o
);

  logic [N*DATA_W-1:0] mem_q [N];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int r = 0; r < N; r++) mem_q[r] <= '0;
    end else if (wrEn_i) begin
      mem_q[wrRow_i] <= wrData_i;
    end
  end

  always_comb begin
    rdData_o = '0;
    for (int i = 0; i < N; i++) begin
      rdData_o[laneLsb(i, DATA_W) +: DATA_W] =
        mem_q[rdRow_i[i*IW +: IW]][laneLsb(int'(rdCol_i[i*IW +: IW]), DATA_W) +: DATA_W];
    end
  end

endmodule

// File: rtl/systolic_input_feeder.sv
// Buffers an N x N activation matrix and streams it diagonally skewed into the array.
// Define FEEDER_TRANSPOSE_EN to stream columns of A per lane instead of rows.
module systolic_input_feeder
  import feeder_pkg::*;
#(
  parameter int DATA_W       = FEEDER_DATA_W,
  parameter int N            = 2,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*DATA_W-1:0] in_row,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [N*DATA_W-1:0] a_out,
  output logic                a_valid
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int RW = $clog2(N + 1);
  localparam int TW = $clog2(2 * N - 1) + 1;
  localparam int DW = $clog2(DRAIN_CYCLES + 1) + 1;

  localparam logic [RW-1:0] ROW_LAST   = RW'(N - 1);
  localparam logic [RW-1:0] ROWS_FULL  = RW'(N);
  localparam logic [TW-1:0] T_LAST     = TW'(2 * N - 2);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES);

  state_e              state_q, state_d;
  logic [RW-1:0]       rowCnt_q, rowCnt_d;
  logic [TW-1:0]       t_q, t_d;
  logic [DW-1:0]       drain_q, drain_d;
  logic                inReady_q, inReady_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                aValid_q, aValid_d;
  logic [N*DATA_W-1:0] aOut_q, aOut_d;

  logic                wrEn;
  logic [N*IW-1:0]     rdRow, rdCol;
  logic [N*DATA_W-1:0] rdData, skewOut;
  logic [N-1:0]        laneOn;
  logic [IW-1:0]       skewK;

  assign wrEn = in_valid & inReady_q;

  feeder_row_buffer #(.DATA_W(DATA_W), .N(N), .IW(IW)) u_buf (
    .clk_i   (clk),
    .reset_i (reset),
    .wrEn_i  (wrEn),
    .wrRow_i (IW'(rowCnt_q)),
    .wrData_i(in_row),
    .rdRow_i (rdRow),
    .rdCol_i (rdCol),
    .rdData_o(rdData)
  );

  // Lane i sees element t-i of its row (or column) while that index is inside the matrix.
  always_comb begin
    rdRow   = '0;
    rdCol   = '0;
    laneOn  = '0;
    skewK   = '0;
    skewOut = '0;
    for (int i = 0; i < N; i++) begin
      laneOn[i] = (int'(t_q) >= i) && (int'(t_q) - i < N);
      skewK     = IW'(int'(t_q) - i);
`ifdef FEEDER_TRANSPOSE_EN
      rdRow[i*IW +: IW] = skewK;
      rdCol[i*IW +: IW] = IW'(i);
`else
      rdRow[i*IW +: IW] = IW'(i);
      rdCol[i*IW +: IW] = skewK;
`endif
      if (laneOn[i]) skewOut[laneLsb(i, DATA_W) +: DATA_W] = rdData[laneLsb(i, DATA_W) +: DATA_W];
    end
  end

  always_comb begin
    state_d  = state_q;
    rowCnt_d = rowCnt_q;
    t_d      = t_q;
    drain_d  = drain_q;
    aOut_d   = '0;
    aValid_d = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE, LOAD: begin
        if (wrEn) begin
          rowCnt_d = rowCnt_q + RW'(1);
          state_d  = (rowCnt_q == ROW_LAST) ? READY : LOAD;
        end
      end
      READY: begin
        if (start) begin
          state_d = STREAM;
          t_d     = '0;
        end
      end
      STREAM: begin
        aValid_d = 1'b1;
        aOut_d   = skewOut;
        if (t_q == T_LAST) begin
          state_d = DRAIN;
          drain_d = '0;
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      DRAIN: begin
        // The extra DRAIN step after the zero cycles is the done cycle itself.
        if (drain_q == DRAIN_LAST) begin
          state_d  = IDLE;
          done_d   = 1'b1;
          rowCnt_d = '0;
        end else begin
          aValid_d = 1'b1;
          drain_d  = drain_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    inReady_d = ((state_d == IDLE) || (state_d == LOAD)) && (rowCnt_d < ROWS_FULL);
    busy_d    = (state_d == STREAM) || (state_d == DRAIN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rowCnt_q  <= '0;
      t_q       <= '0;
      drain_q   <= '0;
      inReady_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aValid_q  <= 1'b0;
      aOut_q    <= '0;
    end else begin
      state_q   <= state_d;
      rowCnt_q  <= rowCnt_d;
      t_q       <= t_d;
      drain_q   <= drain_d;
      inReady_q <= inReady_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aValid_q  <= aValid_d;
      aOut_q    <= aOut_d;
    end
  end

  assign in_ready = inReady_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign a_valid  = aValid_q;
  assign a_out    = aOut_q;

endmodule

// File: tb/tb_systolic_input_feeder.sv
// Scoreboard bench for systolic_input_feeder (N=2, DRAIN_CYCLES=3); honours FEEDER_TRANSPOSE_EN.
module tb_systolic_input_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_row;
  logic        start;
  logic        busy;
  logic        done;
  logic [31:0] a_out;
  logic        a_valid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        isDone;
    logic [15:0] l0;
    logic [15:0] l1;
  } expItem_t;

  expItem_t expQ[$];

  logic [15:0] expA0[3], expA1[3], expB0[3], expB1[3];

  systolic_input_feeder #(.DATA_W(16), .N(2), .DRAIN_CYCLES(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_row  (in_row),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .a_out   (a_out),
    .a_valid (a_valid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drives one row and waits (bounded) for it to be accepted.
  task automatic applyStimulus(input logic [15:0] e0, input logic [15:0] e1);
    bit sent = 0;
    in_valid = 1'b1;
    in_row   = {e1, e0};
    for (int n = 0; n < 20 && !sent; n++) begin
      if (in_ready === 1'b1) sent = 1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!sent) checkOutput("row_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic pushStream(input bit useB, input int count);
    expItem_t it;
    for (int k = 0; k < count; k++) begin
      it.isDone = (k == 6);
      it.l0 = 16'd0;
      it.l1 = 16'd0;
      if (k < 3) begin
        it.l0 = useB ? expB0[k] : expA0[k];
        it.l1 = useB ? expB1[k] : expA1[k];
      end
      expQ.push_back(it);
    end
  endtask

  task automatic startAndCheck(input bit useB);
    int n;
    pushStream(useB, 7);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("busy_after_start", busy, 1);
    checkOutput("valid_latency", a_valid, 0);
    for (n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) break;
    end
    checkOutput("start_to_done_cycles", n, 7);
    checkOutput("done_cycle_in_ready", in_ready, 1);
    checkOutput("done_cycle_busy", busy, 0);
    checkOutput("done_cycle_valid", a_valid, 0);
  endtask

  // Monitor: every cycle the DUT presents data or done, pop and compare.
  always @(negedge clk) begin
    expItem_t e;
    if (a_valid === 1'b1 || done === 1'b1) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_output: valid=%0b done=%0b lanes=(%0d,%0d), expected nothing",
                 a_valid, done, a_out[15:0], a_out[31:16]);
      end else begin
        e = expQ.pop_front();
        if (done !== e.isDone || a_valid !== !e.isDone || a_out[15:0] !== e.l0 || a_out[31:16] !== e.l1) begin
          errors++;
          $display("[TB] FAIL stream_item: got valid=%0b done=%0b lanes=(%0d,%0d), expected valid=%0b done=%0b lanes=(%0d,%0d)",
                   a_valid, done, a_out[15:0], a_out[31:16], !e.isDone, e.isDone, e.l0, e.l1);
        end
      end
    end
  end

  initial begin
    #100000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
`ifdef FEEDER_TRANSPOSE_EN
    expA0 = '{16'd11, 16'd21, 16'd0};  expA1 = '{16'd0, 16'd12, 16'd22};
    expB0 = '{16'd5,  16'd7,  16'd0};  expB1 = '{16'd0, 16'd6,  16'd8};
`else
    expA0 = '{16'd11, 16'd12, 16'd0};  expA1 = '{16'd0, 16'd21, 16'd22};
    expB0 = '{16'd5,  16'd6,  16'd0};  expB1 = '{16'd0, 16'd7,  16'd8};
`endif
    reset    = 1'b1;
    in_valid = 1'b0;
    in_row   = '0;
    start    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] reset state");
    checkOutput("reset_in_ready", in_ready, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_a_valid", a_valid, 0);
    checkOutput("reset_a_out", a_out, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("post_reset_in_ready", in_ready, 1);
    checkOutput("post_reset_a_valid", a_valid, 0);

    $display("[TB] load and stream A");
    applyStimulus(16'd11, 16'd12);
    checkOutput("load_in_ready", in_ready, 1);
    applyStimulus(16'd21, 16'd22);
    checkOutput("ready_in_ready", in_ready, 0);
    startAndCheck(1'b0);

    $display("[TB] back-to-back load of B with over-driven handshake");
    in_valid = 1'b1;
    in_row   = {16'd6, 16'd5};
    start    = 1'b1;
    @(posedge clk); #1;
    checkOutput("b2b_row0_in_ready", in_ready, 1);
    in_row = {16'd8, 16'd7};
    @(posedge clk); #1;
    checkOutput("b2b_ready_drop", in_ready, 0);
    checkOutput("start_in_load_ignored", busy, 0);
    start  = 1'b0;
    in_row = {16'd99, 16'd98};
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("third_row_refused", in_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("start_not_queued", busy, 0);
    startAndCheck(1'b1);

    $display("[TB] reset mid-stream");
    applyStimulus(16'd11, 16'd12);
    applyStimulus(16'd21, 16'd22);
    pushStream(1'b0, 1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    checkOutput("midstream_valid_before_reset", a_valid, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort_a_valid", a_valid, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("abort_idle_busy", busy, 0);
    checkOutput("abort_idle_in_ready", in_ready, 1);
    applyStimulus(16'd11, 16'd12);
    applyStimulus(16'd21, 16'd22);
    startAndCheck(1'b0);

    repeat (5) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
